alu_serial: RTL and testbench

Bit-serial ALU for the area-reduced execute path. Processes one operand bit per clock, LSB first, over WIDTH cycles, with a start/busy/done handshake. Internally it drives a single 1-bit ALU slice (AND/OR/sum/less select, b-invert, carry in/out). It also sequences that slice's carry chain and its `less` input, which in the parallel ALU are wired combinationally. It sits beside the parallel ALU and is selected for multi-cycle issue.

---
 rtl/alu_serial.sv | 120 ++++++++++++
 tb/tb_alu_serial.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU, one operand bit per clock, LSB first.
// A single 1-bit slice (AND/OR/sum/less, b-invert, carry in/out) is reused
// for every bit. The slice carry is held in a register between cycles.
// Build option: define ALU_SERIAL_OVF_EN to drive the overflow output and
// to use the overflow-corrected signed compare for SLT. Without it,
// overflow is tied low and SLT uses the raw MSB sum, as the parallel ALU does.
module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [2:0]       op_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             ai, bi, s_sum, s_cout, s_out, last, set;
  logic [WIDTH-1:0] res_next, fin;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf;
`endif

  // One slice evaluation on the current LSBs of the operand shift registers.
  always_comb begin
    ai     = a_sr[0];
    bi     = b_sr[0] ^ op_r[2];
    s_sum  = ai ^ bi ^ carry;
    s_cout = (ai & bi) | (carry & (ai ^ bi));
    case (op_r[1:0])
      2'b00:   s_out = ai & bi;
      2'b01:   s_out = ai | bi;
      2'b10:   s_out = s_sum;
      default: s_out = 1'b0;  // less input is 0 at every bit during RUN
    endcase
    last     = (cnt == CW'(WIDTH - 1));
    res_next = {s_out, res_sr};
`ifdef ALU_SERIAL_OVF_EN
    // On the last cycle, carry holds carry into the MSB and s_cout is carry out.
    ovf = op_r[1] & (carry ^ s_cout);
    set = s_sum ^ ovf;
`else
    set = s_sum;
`endif
    fin = (op_r[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, set} : res_next;
  end

  // Control FSM, operand/result shifting and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= '0;
`ifdef ALU_SERIAL_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= s_cout;
          res_sr <= res_next[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fin;
            zero   <= (fin == '0);
`ifdef ALU_SERIAL_OVF_EN
            overflow <= ovf;
`endif
          end
        end
        default: begin  // IDLE or DONE: accept a new operation
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op_r  <= op;
            carry <= op[2];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifndef ALU_SERIAL_OVF_EN
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: randomized + directed scoreboard bench for alu_serial.
// Stimulus pushes expected results into a queue; a monitor pops on done.
module tb_alu_serial;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result;

  alu_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    int           t;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: whole-word arithmetic from the op encoding.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] yy;
    logic [W:0]   s;
    logic         ovf, set;
    yy  = o[2] ? ~y : y;
    s   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, o[2]};
    ovf = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
`ifdef ALU_SERIAL_OVF_EN
    set = s[W-1] ^ ovf;
`else
    set = s[W-1];
`endif
    case (o[1:0])
      2'b00:   e.res = x & yy;
      2'b01:   e.res = x | yy;
      2'b10:   e.res = s[W-1:0];
      default: e.res = {{(W-1){1'b0}}, set};
    endcase
    e.z = (e.res == '0);
`ifdef ALU_SERIAL_OVF_EN
    e.ov = o[1] ? ovf : 1'b0;
`else
    e.ov = 1'b0;
`endif
    e.t = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom());
    endcase
  endfunction

  // Wait (bounded) at a falling edge until the DUT can accept a start.
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("ready_timeout", 1, 0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    wait_ready();
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    e   = model(o, x, y);
    e.t = cyc;
    q.push_back(e);
    last_exp = e;
    start = 1'b0; a = W'($urandom()); b = W'($urandom()); op = 3'($urandom());
  endtask

  // Monitor: compare every done against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("busy_with_done", {63'b0, busy}, 64'd0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("zero", zero, e.z);
          chk("overflow", overflow, e.ov);
          chk("latency", cyc, e.t + W);
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // Directed cases
    issue(3'b010, 32'd5, 32'd7);
    issue(3'b110, 32'd3, 32'd3);
    issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(3'b111, 32'hFFFF_FFFF, 32'd1);
    issue(3'b111, 32'd1, 32'hFFFF_FFFF);
    issue(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
    issue(3'b010, 32'h7FFF_FFFF, 32'd1);
    issue(3'b010, 32'd1, 32'd1);            // back-to-back during DONE
    issue(3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F);
    issue(3'b011, 32'h8000_0000, 32'h8000_0000);
    issue(3'b101, 32'h0000_00FF, 32'hFFFF_FF00);

    // Result holds while the next operation runs
    wait_ready();
    issue(3'b010, 32'd100, 32'd23);
    wait_ready();
    issue(3'b110, 32'd9, 32'd4);
    repeat (5) @(negedge clk);
    chk("hold_result", result, 32'd123);

    // Start during RUN is ignored
    repeat (5) @(negedge clk);
    start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; op = 3'b010;
    @(negedge clk);
    start = 1'b0;

    // Random operations
    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick());

    // Reset mid-RUN aborts without a done pulse
    issue(3'b001, 32'hDEAD_BEEF, 32'h0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    void'(q.pop_back());
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // One more operation after the abort
    issue(3'b110, 32'd10, 32'd20);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
